// File: rtl/gate_exerciser_pkg.sv
// Shared encodings for the gate exerciser: gate function select and FSM states.
// Imported by the exerciser top and the reusable gate_expect model.
package gate_exerciser_pkg;

    localparam logic [1:0] GATE_AND  = 2'b00;
    localparam logic [1:0] GATE_OR   = 2'b01;
    localparam logic [1:0] GATE_XOR  = 2'b10;
    localparam logic [1:0] GATE_NAND = 2'b11;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETTLE = 2'b01,
        ST_SAMPLE = 2'b10,
        ST_DONE   = 2'b11
    } state_t;

endpackage

// File: rtl/gate_exerciser_expect.sv
// Combinational reference model of a 2-input gate selected by sel.
// Reusable by other lab checkers.
module gate_expect
    import gate_exerciser_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic [1:0] sel,
    output logic       y
);

    always_comb begin
        y = 1'b0;
        unique case (sel)
            GATE_AND:  y = a & b;
            GATE_OR:   y = a | b;
            GATE_XOR:  y = a ^ b;
            GATE_NAND: y = ~(a & b);
            default:   y = 1'b0;
        endcase
    end

endmodule

// File: rtl/gate_exerciser.sv
// Drives a 2-input gate through 00,01,10,11, samples its output after a settle
// time and reports pass plus a per-vector mismatch mask.
module gate_exerciser
    import gate_exerciser_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] gate_sel,
    input  logic       gate_out,
    output logic       input1,
    output logic       input2,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_mask
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       vec_q, vec_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       mask_q, mask_d;
    logic             pass_q, pass_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             in1_q, in1_d;
    logic             in2_q, in2_d;
    logic             exp_y;
    logic             mism;

    gate_expect u_expect (
        .a   (vec_q[1]),
        .b   (vec_q[0]),
        .sel (sel_q),
        .y   (exp_y)
    );

    assign mism = (gate_out != exp_y);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sel_q   <= GATE_AND;
            vec_q   <= 2'd0;
            cnt_q   <= '0;
            mask_q  <= 4'b0000;
            pass_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            in1_q   <= 1'b0;
            in2_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            pass_q  <= pass_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            in1_q   <= in1_d;
            in2_q   <= in2_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (start) state_d = ST_SETTLE;
            ST_SETTLE: if (cnt_q == '0) state_d = ST_SAMPLE;
            ST_SAMPLE: state_d = (vec_q == 2'd3) ? ST_DONE : ST_SETTLE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Run datapath: select latch, vector index, settle counter, result.
    always_comb begin
        sel_d  = sel_q;
        vec_d  = vec_q;
        cnt_d  = cnt_q;
        mask_d = mask_q;
        pass_d = pass_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sel_d  = gate_sel;
                    vec_d  = 2'd0;
                    cnt_d  = RELOAD;
                    mask_d = 4'b0000;
                    pass_d = 1'b0;
                end
            end
            ST_SETTLE: begin
                if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
            end
            ST_SAMPLE: begin
                mask_d = mask_q | ({3'b000, mism} << vec_q);
                if (vec_q == 2'd3) begin
                    pass_d = (mask_d == 4'b0000);
                end else begin
                    vec_d = vec_q + 2'd1;
                    cnt_d = RELOAD;
                end
            end
            default: ;
        endcase
    end

    // Outputs are registered from the next state so they align with it.
    always_comb begin
        busy_d = (state_d == ST_SETTLE) || (state_d == ST_SAMPLE);
        done_d = (state_d == ST_DONE);
        in1_d  = busy_d ? vec_d[1] : 1'b0;
        in2_d  = busy_d ? vec_d[0] : 1'b0;
    end

    assign input1    = in1_q;
    assign input2    = in2_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_mask = mask_q;

endmodule

// File: tb/tb_gate_exerciser.sv
// Scoreboard bench for gate_exerciser: directed runs push expected results,
// monitors pop and compare on every done pulse.
module tb_gate_exerciser;

    typedef struct {
        int         due;
        logic       pass;
        logic [3:0] mask;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, start1;
    logic [1:0] gate_sel, gate_sel1;
    logic       input1, input2, busy, done, pass;
    logic [3:0] fail_mask;
    logic       in1_b, in2_b, busy1, done1, pass1;
    logic [3:0] mask1;
    logic       gate_out;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   e0       = -1000;
    bit   run_active = 1'b0;
    bit   mon_en     = 1'b0;
    int   d;
    bit   exp_busy;
    exp_t q0[$];
    exp_t q1[$];
    exp_t ent;
    exp_t ent1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // AND gate under test for the default instance
    assign gate_out = input1 & input2;

    gate_exerciser dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .gate_sel  (gate_sel),
        .gate_out  (gate_out),
        .input1    (input1),
        .input2    (input2),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail_mask (fail_mask)
    );

    gate_exerciser #(.SETTLE_CYCLES(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .start     (start1),
        .gate_sel  (gate_sel1),
        .gate_out  (1'b1),
        .input1    (in1_b),
        .input2    (in2_b),
        .busy      (busy1),
        .done      (done1),
        .pass      (pass1),
        .fail_mask (mask1)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Per-cycle monitor of the default instance plus its scoreboard.
    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            d = cyc - e0;
            exp_busy = run_active && d >= 0 && d < 20;
            chk("busy", {31'd0, busy}, {31'd0, exp_busy});
            chk("vector", {30'd0, input1, input2},
                exp_busy ? 32'(d / 5) : 32'd0);
            if (done) begin
                if (q0.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    ent = q0.pop_front();
                    chk("done_cycle", 32'(cyc), 32'(ent.due));
                    chk("pass", {31'd0, pass}, {31'd0, ent.pass});
                    chk("fail_mask", {28'd0, fail_mask}, {28'd0, ent.mask});
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (mon_en && done1) begin
            if (q1.size() == 0) begin
                chk("unexpected_done1", 32'd1, 32'd0);
            end else begin
                ent1 = q1.pop_front();
                chk("done1_cycle", 32'(cyc), 32'(ent1.due));
                chk("pass1", {31'd0, pass1}, {31'd0, ent1.pass});
                chk("fail_mask1", {28'd0, mask1}, {28'd0, ent1.mask});
                chk("busy1_in_done", {31'd0, busy1}, 32'd0);
            end
        end
    end

    task automatic run0(input logic [1:0] sel, input logic p,
                        input logic [3:0] m);
        @(negedge clk);
        gate_sel   = sel;
        start      = 1'b1;
        e0         = cyc + 1;
        run_active = 1'b1;
        q0.push_back('{e0 + 20, p, m});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_q0(input int limit);
        int n = 0;
        while (q0.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (q0.size() != 0) begin
            chk("timeout_q0", 32'd1, 32'd0);
            q0.delete();
        end
    endtask

    task automatic wait_cyc(input int c);
        int n = 0;
        while (cyc < c && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        start1    = 1'b0;
        gate_sel  = 2'b00;
        gate_sel1 = 2'b00;

        // Reset for two edges with start pulsed meanwhile
        @(negedge clk);
        start  = 1'b1;
        start1 = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        start1 = 1'b0;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_pass", {31'd0, pass}, 32'd0);
        chk("rst_mask", {28'd0, fail_mask}, 32'd0);
        chk("rst_inputs", {30'd0, input1, input2}, 32'd0);
        chk("rst1_all", {24'd0, busy1, done1, pass1, in1_b, mask1}, 32'd0);
        rst    = 1'b0;
        mon_en = 1'b1;
        repeat (3) @(negedge clk);

        // Clean AND run
        run0(2'b00, 1'b1, 4'b0000);
        wait_q0(40);
        repeat (3) @(negedge clk);
        chk("pass_held", {31'd0, pass}, 32'd1);

        // AND gate checked as OR
        run0(2'b01, 1'b0, 4'b0110);
        wait_q0(40);
        repeat (2) @(negedge clk);
        chk("mask_held", {28'd0, fail_mask}, 32'h6);

        // Stuck-at-1 output, SETTLE_CYCLES=1
        @(negedge clk);
        gate_sel1 = 2'b00;
        start1    = 1'b1;
        q1.push_back('{cyc + 1 + 8, 1'b0, 4'b0111});
        @(negedge clk);
        start1 = 1'b0;
        for (int n = 0; n < 30 && q1.size() != 0; n++) @(negedge clk);
        if (q1.size() != 0) begin
            chk("timeout_q1", 32'd1, 32'd0);
            q1.delete();
        end

        // Start re-pulse and select change during a run are ignored
        run0(2'b00, 1'b1, 4'b0000);
        wait_cyc(e0 + 5);
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        gate_sel = 2'b10;
        wait_q0(40);
        repeat (10) @(negedge clk);
        gate_sel = 2'b00;

        // Reset in cycle 9 of a run aborts it without done
        run0(2'b00, 1'b1, 4'b0000);
        wait_cyc(e0 + 8);
        rst        = 1'b1;
        run_active = 1'b0;
        q0.delete();
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_pass", {31'd0, pass}, 32'd0);
        chk("abort_mask", {28'd0, fail_mask}, 32'd0);
        chk("abort_inputs", {30'd0, input1, input2}, 32'd0);
        repeat (30) @(negedge clk);

        run0(2'b00, 1'b1, 4'b0000);
        wait_q0(40);
        repeat (3) @(negedge clk);

        chk("q0_empty", 32'(q0.size()), 32'd0);
        chk("q1_empty", 32'(q1.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
